// File: rtl/ivs_dma_pkg.sv
// Shared DMA definitions: AXI encodings, page/beat geometry and the engine FSM states.
// Used by both the read and write engines.
package ivs_dma_pkg;

  localparam logic [2:0] AXSIZE_16B  = 3'b100;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [3:0] CACHE_MODIF = 4'b0011;

  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned BEAT_BYTES = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } dma_state_e;

endpackage

// File: rtl/ivs_dma_burst_calc.sv
// Burst sizing: the largest INCR burst that fits the remaining beats, the current 4 KB page
// and MAX_BEATS. Returns the beat count n and the matching AXI length (n-1).
module ivs_dma_burst_calc
  import ivs_dma_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 64
) (
  input  logic [11:4] page_addr,
  input  logic [27:0] beats_left,
  output logic [6:0]  n,
  output logic [5:0]  arlen
);

  localparam logic [8:0] PageBeats = 9'(PAGE_BYTES / BEAT_BYTES);
  localparam logic [8:0] MaxBeats  = 9'(MAX_BEATS);

  logic [8:0] page_room;
  logic [8:0] cap;

  always_comb begin
    // Beats left before the page boundary: 1..256.
    page_room = PageBeats - {1'b0, page_addr};
    cap       = (page_room < MaxBeats) ? page_room : MaxBeats;
    n         = (beats_left < {19'd0, cap}) ? beats_left[6:0] : cap[6:0];
    arlen     = 6'(n - 7'd1);
  end

endmodule

// File: rtl/ivs_dma_rd.sv
// DMA read engine: splits a byte region into page-safe INCR bursts on AR, keeps up to MAX_OTS
// bursts outstanding and forwards R beats to the consumer stream with no added latency.
module ivs_dma_rd
  import ivs_dma_pkg::*;
#(
  parameter logic [3:0]  ARID      = 4'h1,
  parameter int unsigned MAX_BEATS = 64,
  parameter int unsigned MAX_OTS   = 4
) (
  input  logic         aclk,
  input  logic         arst,
  input  logic         dr_req,
  input  logic [31:0]  dr_base,
  input  logic [31:0]  dr_len,
  output logic         dr_busy,
  output logic         dr_done,
  output logic         dr_err,
  output logic         dr_valid,
  input  logic         dr_ready,
  output logic [127:0] dr_data,
  output logic         dr_last,
  output logic         arvalid,
  input  logic         arready,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [5:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arlock,
  output logic [3:0]   arcache,
  output logic [2:0]   arport,
  output logic [3:0]   arregion,
  output logic [3:0]   arqos,
  output logic [7:0]   aruser,
  input  logic         rvalid,
  output logic         rready,
  input  logic [3:0]   rid,
  input  logic [127:0] rdata,
  input  logic         rlast,
  input  logic [1:0]   rresp
);

  localparam logic [3:0] MaxOts = 4'(MAX_OTS);

  dma_state_e  state_q;
  logic [31:0] addr_q;
  logic [27:0] beats_left_q;
  logic [27:0] rx_left_q;
  logic [3:0]  ots_q, ots_d;
  logic [6:0]  n_q;
  logic        err_q;
  logic        busy_q;
  logic        done_q;
  logic        arvalid_q;
  logic [31:0] araddr_q;
  logic [5:0]  arlen_q;

  logic [6:0]  calc_n;
  logic [5:0]  calc_arlen;
  logic        ots_nz, ar_hs, r_hs, r_last_hs;
  logic        unused_lsbs;

  assign unused_lsbs = ^{dr_base[3:0], dr_len[3:0]};

  ivs_dma_burst_calc #(
    .MAX_BEATS (MAX_BEATS)
  ) u_burst_calc (
    .page_addr  (addr_q[11:4]),
    .beats_left (beats_left_q),
    .n          (calc_n),
    .arlen      (calc_arlen)
  );

  // R channel is a pure pass-through, gated so stray beats are never accepted when idle.
  assign ots_nz    = (ots_q != 4'd0);
  assign rready    = dr_ready & ots_nz;
  assign dr_valid  = rvalid & ots_nz;
  assign dr_data   = rdata;
  assign dr_last   = dr_valid & (rx_left_q == 28'd1);
  assign ar_hs     = arvalid_q & arready;
  assign r_hs      = rvalid & rready;
  assign r_last_hs = r_hs & rlast;

  assign dr_busy  = busy_q;
  assign dr_done  = done_q;
  assign dr_err   = done_q & err_q;

  assign arvalid  = arvalid_q;
  assign araddr   = araddr_q;
  assign arlen    = arlen_q;
  assign arid     = ARID;
  assign arsize   = AXSIZE_16B;
  assign arburst  = BURST_INCR;
  assign arlock   = 1'b0;
  assign arcache  = CACHE_MODIF;
  assign arport   = 3'd0;
  assign arregion = 4'd0;
  assign arqos    = 4'd0;
  assign aruser   = 8'd0;

  always_comb begin
    ots_d = ots_q;
    if (ar_hs && !r_last_hs) begin
      ots_d = ots_q + 4'd1;
    end else if (!ar_hs && r_last_hs) begin
      ots_d = ots_q - 4'd1;
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q      <= StIdle;
      addr_q       <= 32'd0;
      beats_left_q <= 28'd0;
      rx_left_q    <= 28'd0;
      ots_q        <= 4'd0;
      n_q          <= 7'd0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      arvalid_q    <= 1'b0;
      araddr_q     <= 32'd0;
      arlen_q      <= 6'd0;
    end else begin
      ots_q  <= ots_d;
      done_q <= 1'b0;
      if (r_hs) begin
        rx_left_q <= rx_left_q - 28'd1;
      end
      if (r_hs && ((rresp != RESP_OKAY) || (rid != ARID))) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (dr_req) begin
            addr_q       <= {dr_base[31:4], 4'h0};
            beats_left_q <= dr_len[31:4];
            rx_left_q    <= dr_len[31:4];
            err_q        <= 1'b0;
            if (dr_len[31:4] == 28'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StIssue;
              busy_q  <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (ar_hs) begin
            arvalid_q    <= 1'b0;
            addr_q       <= addr_q + {21'd0, n_q, 4'h0};
            beats_left_q <= beats_left_q - {21'd0, n_q};
            if (beats_left_q == {21'd0, n_q}) begin
              state_q <= StDrain;
            end
          end else if (!arvalid_q && (ots_q < MaxOts)) begin
            // Latch the burst so araddr/arlen hold while the slave stalls.
            arvalid_q <= 1'b1;
            araddr_q  <= addr_q;
            arlen_q   <= calc_arlen;
            n_q       <= calc_n;
          end
        end
        StDrain: begin
          if (ots_q == 4'd0) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ivs_dma_rd.sv
// Scoreboard bench for ivs_dma_rd: a simple AXI read slave, directed requests with
// hand-computed AR bursts and beat data, and a monitor that pops and compares.
module tb_ivs_dma_rd;

  typedef struct { logic [31:0] addr; int len; } burst_t;
  typedef struct { logic [127:0] data; logic last; } beat_t;
  typedef struct { logic [31:0] addr; logic [5:0] len; } ar_t;

  logic         aclk = 1'b0;
  logic         arst = 1'b1;
  logic         dr_req = 1'b0;
  logic [31:0]  dr_base = 32'd0;
  logic [31:0]  dr_len = 32'd0;
  logic         dr_busy, dr_done, dr_err, dr_valid, dr_last;
  logic         dr_ready = 1'b1;
  logic [127:0] dr_data;
  logic         arvalid, arlock, rready;
  logic         arready = 1'b1;
  logic [3:0]   arid, arcache, arregion, arqos;
  logic [31:0]  araddr;
  logic [5:0]   arlen;
  logic [2:0]   arsize, arport;
  logic [1:0]   arburst;
  logic [7:0]   aruser;
  logic         rvalid = 1'b0;
  logic [3:0]   rid = 4'h1;
  logic [127:0] rdata = '0;
  logic         rlast = 1'b0;
  logic [1:0]   rresp = 2'b00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ar_cnt = 0;
  int rlast_cnt = 0;
  int beat_no = 0;
  int beats_seen = 0;
  int stable_cnt = 0;
  int last_hs_cyc = 0;
  int done_cyc = 0;
  int bad_resp = -1;
  int bad_rid = -1;
  int ar_stall = 0;
  bit rvalid_en = 1'b1;
  bit ready_toggle = 1'b0;

  burst_t sl_q[$];
  int     sl_beat = 0;
  beat_t  exp_beats[$];
  ar_t    exp_ar[$];

  ivs_dma_rd dut (
    .aclk     (aclk),
    .arst     (arst),
    .dr_req   (dr_req),
    .dr_base  (dr_base),
    .dr_len   (dr_len),
    .dr_busy  (dr_busy),
    .dr_done  (dr_done),
    .dr_err   (dr_err),
    .dr_valid (dr_valid),
    .dr_ready (dr_ready),
    .dr_data  (dr_data),
    .dr_last  (dr_last),
    .arvalid  (arvalid),
    .arready  (arready),
    .arid     (arid),
    .araddr   (araddr),
    .arlen    (arlen),
    .arsize   (arsize),
    .arburst  (arburst),
    .arlock   (arlock),
    .arcache  (arcache),
    .arport   (arport),
    .arregion (arregion),
    .arqos    (arqos),
    .aruser   (aruser),
    .rvalid   (rvalid),
    .rready   (rready),
    .rid      (rid),
    .rdata    (rdata),
    .rlast    (rlast),
    .rresp    (rresp)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic logic [127:0] mkdata(input logic [31:0] a);
    return {a ^ 32'hDEADBEEF, ~a, a + 32'h01234567, a};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [5:0] l);
    ar_t e;
    e.addr = a;
    e.len  = l;
    exp_ar.push_back(e);
  endtask

  // Drive one request (sampled at the next rising edge) and queue its expected beats.
  task automatic start(input logic [31:0] base, input logic [31:0] len);
    beat_t b;
    int nb;
    nb = int'(len >> 4);
    for (int i = 0; i < nb; i++) begin
      b.data = mkdata({base[31:4], 4'h0} + 32'(i * 16));
      b.last = (i == nb - 1);
      exp_beats.push_back(b);
    end
    @(negedge aclk); #3;
    dr_base = base;
    dr_len  = len;
    dr_req  = 1'b1;
    @(posedge aclk); #1;
    dr_req  = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic exp_err, input int bound);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < bound && !seen; n++) begin
      @(negedge aclk); #3;
      if (dr_done) seen = 1'b1;
    end
    done_cyc = cyc;
    chk({name, "_done_seen"}, 128'(seen), 128'd1);
    if (seen) begin
      chk({name, "_err"}, 128'(dr_err), 128'(exp_err));
      chk({name, "_busy_low"}, 128'(dr_busy), 128'd0);
      chk({name, "_beats_left"}, 128'(exp_beats.size()), 128'd0);
      chk({name, "_ars_left"}, 128'(exp_ar.size()), 128'd0);
    end
  endtask

  // AXI read slave: returns mkdata(address) for every beat of each accepted burst.
  initial begin : slave
    logic [31:0] a;
    forever begin
      @(negedge aclk);
      if (ar_stall > 0) begin
        arready = 1'b0;
        ar_stall--;
      end else begin
        arready = 1'b1;
      end
      dr_ready = ready_toggle ? ~dr_ready : 1'b1;
      if (rvalid_en && sl_q.size() > 0) begin
        a      = sl_q[0].addr + 32'(sl_beat * 16);
        rvalid = 1'b1;
        rdata  = mkdata(a);
        rlast  = (sl_beat == sl_q[0].len);
        rid    = (beat_no == bad_rid) ? 4'h3 : 4'h1;
        rresp  = (beat_no == bad_resp) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
      end
      #1;
      if (arvalid && arready) begin
        burst_t bu;
        bu.addr = araddr;
        bu.len  = int'(arlen);
        sl_q.push_back(bu);
      end
      if (rvalid && rready) begin
        beat_no++;
        if (rlast) begin
          sl_beat = 0;
          sl_q.delete(0);
          rlast_cnt++;
        end else begin
          sl_beat++;
        end
      end
    end
  end

  initial begin : monitor
    bit          stalled;
    logic [31:0] st_addr;
    logic [5:0]  st_len;
    ar_t         ea;
    beat_t       eb;
    stalled = 1'b0;
    st_addr = '0;
    st_len  = '0;
    forever begin
      @(negedge aclk); #2;
      if (arst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("ar_held", 128'(arvalid), 128'd1);
          chk("ar_addr_stable", 128'(araddr), 128'(st_addr));
          chk("ar_len_stable", 128'(arlen), 128'(st_len));
          stable_cnt++;
        end
        stalled = arvalid && !arready;
        st_addr = araddr;
        st_len  = arlen;
        if (arvalid && arready) begin
          ar_cnt++;
          if (exp_ar.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ar actual=%0h/%0d required=none", araddr, arlen);
          end else begin
            ea = exp_ar.pop_front();
            chk("ar_addr", 128'(araddr), 128'(ea.addr));
            chk("ar_len", 128'(arlen), 128'(ea.len));
          end
        end
        if (dr_valid && dr_ready) begin
          beats_seen++;
          if (exp_beats.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none", dr_data);
          end else begin
            eb = exp_beats.pop_front();
            chk("beat_data", dr_data, eb.data);
            chk("beat_last", 128'(dr_last), 128'(eb.last));
            if (eb.last) last_hs_cyc = cyc;
          end
        end
        if (!dr_ready) chk("rready_tracks", 128'(rready), 128'd0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    int ar0, rl0, st0;
    bit seen;
    repeat (2) @(negedge aclk);
    #3;
    chk("rst_busy", 128'(dr_busy), 128'd0);
    chk("rst_done", 128'(dr_done), 128'd0);
    chk("rst_arvalid", 128'(arvalid), 128'd0);
    chk("rst_arsize", 128'(arsize), 128'h4);
    chk("rst_arburst", 128'(arburst), 128'h1);
    chk("rst_arcache", 128'(arcache), 128'h3);
    chk("rst_arid", 128'(arid), 128'h1);
    arst = 1'b0;

    // 1: single full burst
    push_ar(32'h1000, 6'd63);
    start(32'h1000, 32'h400);
    wait_done("t1", 1'b0, 400);
    chk("t1_done_latency", 128'(done_cyc - last_hs_cyc), 128'd2);

    // 2: page crossing splits into 1 + 3 beats
    push_ar(32'h0FF0, 6'd0);
    push_ar(32'h1000, 6'd2);
    start(32'h0FF0, 32'h40);
    wait_done("t2", 1'b0, 100);

    // 3: outstanding limit
    rvalid_en = 1'b0;
    ar0 = ar_cnt;
    for (int i = 0; i < 8; i++) push_ar(32'(i * 32'h400), 6'd63);
    start(32'h0, 32'h2000);
    repeat (30) @(negedge aclk);
    #3;
    chk("t3_ars_at_limit", 128'(ar_cnt - ar0), 128'd4);
    chk("t3_arvalid_low", 128'(arvalid), 128'd0);
    rl0 = rlast_cnt;
    rvalid_en = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge aclk); #3;
      if (rlast_cnt > rl0) seen = 1'b1;
    end
    chk("t3_first_rlast", 128'(seen), 128'd1);
    chk("t3_no_fifth_before_rlast", 128'(ar_cnt - ar0), 128'd4);
    repeat (6) @(negedge aclk);
    #3;
    chk("t3_fifth_after_rlast", 128'(ar_cnt - ar0), 128'd5);
    wait_done("t3", 1'b0, 2000);
    chk("t3_total_ars", 128'(ar_cnt - ar0), 128'd8);

    // 4: AR stall, back-pressure toggling, request while busy ignored
    ready_toggle = 1'b1;
    ar0 = ar_cnt;
    st0 = stable_cnt;
    push_ar(32'h2000, 6'd63);
    push_ar(32'h2400, 6'd63);
    start(32'h2000, 32'h800);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge aclk); #3;
      if (ar_cnt > ar0) seen = 1'b1;
    end
    chk("t4_first_ar", 128'(seen), 128'd1);
    ar_stall = 6;
    dr_base = 32'h9000;
    dr_len  = 32'h100;
    dr_req  = 1'b1;
    @(posedge aclk); #1;
    dr_req  = 1'b0;
    wait_done("t4", 1'b0, 1000);
    ready_toggle = 1'b0;
    chk("t4_stall_observed", 128'(stable_cnt - st0 >= 3), 128'd1);

    // 5: error beats still forwarded, error reported, then cleared
    bad_resp = beat_no + 3;
    bad_rid  = beat_no + 7;
    push_ar(32'h3000, 6'd15);
    start(32'h3000, 32'h100);
    wait_done("t5", 1'b1, 200);
    bad_resp = -1;
    bad_rid  = -1;
    push_ar(32'h3400, 6'd3);
    start(32'h3400, 32'h40);
    wait_done("t5_clean", 1'b0, 100);

    // 6: zero length, then reset mid-burst and a clean restart
    ar0 = ar_cnt;
    start(32'h6000, 32'h0);
    wait_done("t6_zero", 1'b0, 3);
    chk("t6_zero_no_ar", 128'(ar_cnt - ar0), 128'd0);
    rl0 = beats_seen;
    push_ar(32'h4000, 6'd63);
    start(32'h4000, 32'h400);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge aclk); #3;
      if (beats_seen >= rl0 + 5) seen = 1'b1;
    end
    chk("t6_mid_burst", 128'(seen), 128'd1);
    @(negedge aclk);
    arst = 1'b1;
    #3;
    chk("t6_rst_busy", 128'(dr_busy), 128'd0);
    chk("t6_rst_valid", 128'(dr_valid), 128'd0);
    chk("t6_rst_rready", 128'(rready), 128'd0);
    chk("t6_rst_arvalid", 128'(arvalid), 128'd0);
    chk("t6_rst_araddr", 128'(araddr), 128'd0);
    chk("t6_rst_last", 128'(dr_last), 128'd0);
    sl_q.delete();
    sl_beat = 0;
    exp_beats.delete();
    exp_ar.delete();
    repeat (2) @(negedge aclk);
    #3;
    arst = 1'b0;
    push_ar(32'h5000, 6'd7);
    start(32'h5000, 32'h80);
    wait_done("t6_restart", 1'b0, 100);

    repeat (3) @(negedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
